// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding a uart: presents one byte at a time on
// uart_start/uart_tx_in and holds it until the uart reports tx_done.
module uart_tx_feeder #(
    parameter int DEPTH    = 16,
    parameter int IDLE_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       uart_start,
    output logic [7:0]                 uart_tx_in,
    input  logic                       uart_tx_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg, overflow_reg, done_d_reg;
    state_t        state_reg, state_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          start_reg, start_next;
    logic [7:0]    tx_reg, tx_next;

    logic push, pop, done_rise;

    assign push      = wr_en & ~full_reg;
    assign pop       = (state_reg == IDLE) & ~empty_reg;
    assign done_rise = uart_tx_done & ~done_d_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            done_d_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg  <= count_next;
            full_reg   <= (count_next == CW'(DEPTH));
            empty_reg  <= (count_next == '0);
            done_d_reg <= uart_tx_done;
            if (wr_en && full_reg) overflow_reg <= 1'b1;
        end
    end

    // The IDLE cycle before a pop counts as the last gap cycle, so GAP itself
    // lasts IDLE_GAP-1 cycles and uart_start is low for exactly IDLE_GAP cycles.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        start_next   = start_reg;
        tx_next      = tx_reg;
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    tx_next    = mem[rd_ptr_reg];
                    start_next = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (done_rise) begin
                    start_next = 1'b0;
                    if (IDLE_GAP == 1) begin
                        state_next = IDLE;
                    end else begin
                        gap_cnt_next = GW'(IDLE_GAP - 1);
                        state_next   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg <= GW'(1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            start_reg   <= 1'b0;
            tx_reg      <= 8'h00;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            start_reg   <= start_next;
            tx_reg      <= tx_next;
        end
    end

    assign full       = full_reg;
    assign empty      = empty_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg != IDLE);
    assign uart_start = start_reg;
    assign uart_tx_in = tx_reg;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed steps plus random traffic, checked every
// cycle against a queue/timeline model of the feeder and a simple uart responder.
module tb_uart_tx_feeder;
    localparam int DEPTH    = 16;
    localparam int IDLE_GAP = 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, overflow, busy, uart_start;
    logic [CW-1:0] count;
    logic [7:0]    uart_tx_in;
    logic          uart_tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .IDLE_GAP(IDLE_GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .busy         (busy),
        .uart_start   (uart_start),
        .uart_tx_in   (uart_tx_in),
        .uart_tx_done (uart_tx_done)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: stored bytes, byte in flight, and the cycle from which
    // the sequencer is idle again after a completed byte.
    logic [7:0] m_q[$];
    logic [7:0] acc_log[$];
    logic [7:0] got_q[$];
    logic [7:0] m_byte;
    bit         m_inflight, m_done_d, m_ovf;
    int         m_idle_from;

    logic prev_start;
    int   low_run, peak;
    bit   b2b, resp_en;
    int   resp_pct = 30;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight  = 1'b0;
        m_byte      = 8'h00;
        m_idle_from = -1;
        m_done_d    = 1'b0;
        m_ovf       = 1'b0;
        prev_start  = 1'b0;
        low_run     = 0;
        b2b         = 1'b0;
    endtask

    task automatic compare_all();
        chk("uart_start", 32'(uart_start), 32'(m_inflight));
        if (m_inflight) chk("uart_tx_in", 32'(uart_tx_in), 32'(m_byte));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("busy", 32'(busy), 32'(m_inflight || (cyc < m_idle_from)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic tick();
        logic       pw, td;
        logic [7:0] pd;
        int         sz;
        bit         pop, rise;
        pw = wr_en;
        pd = wr_data;
        td = uart_tx_done;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            sz   = m_q.size();
            pop  = !m_inflight && (cyc > m_idle_from) && (sz > 0);
            rise = td && !m_done_d && m_inflight;
            if (pop) begin
                m_byte     = m_q.pop_front();
                m_inflight = 1'b1;
            end
            if (rise) begin
                m_inflight  = 1'b0;
                m_idle_from = cyc + IDLE_GAP - 1;
            end
            if (pw && sz < DEPTH) begin
                m_q.push_back(pd);
                acc_log.push_back(pd);
            end
            if (pw && sz >= DEPTH) m_ovf = 1'b1;
            m_done_d = td;
        end
        #1;
        compare_all();
        if (int'(count) > peak) peak = int'(count);
        // Monitor: collect presented bytes and measure back-to-back gaps
        if (!uart_start) begin
            if (prev_start) begin
                low_run = 1;
                b2b     = (m_q.size() != 0);
            end else begin
                low_run++;
            end
        end else if (!prev_start) begin
            got_q.push_back(uart_tx_in);
            $display("byte %0d presented: %02h (cycle %0d)", got_q.size() - 1, uart_tx_in, cyc);
            if (b2b) chk("gap_len", 32'(low_run), 32'(IDLE_GAP));
            b2b = 1'b0;
        end
        prev_start = uart_start;
        if (resp_en) begin
            uart_tx_done = uart_start && !uart_tx_done && ($urandom_range(0, 99) < resp_pct);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        resp_en = 1'b1;
        while ((m_inflight || m_q.size() != 0 || busy) && k < 3000) begin
            tick();
            k++;
        end
        chk("drain_in_time", 32'(k < 3000), 32'd1);
        resp_en      = 1'b0;
        uart_tx_done = 1'b0;
        tick();
    endtask

    task automatic check_delivery(input string tag);
        chk({tag, "_n"}, 32'(got_q.size()), 32'(acc_log.size()));
        for (int i = 0; i < got_q.size() && i < acc_log.size(); i++) begin
            chk({tag, "_order"}, 32'(got_q[i]), 32'(acc_log[i]));
        end
        got_q.delete();
        acc_log.delete();
    endtask

    initial begin
        model_reset();
        resp_en = 1'b0;
        peak    = 0;
        tick();
        tick();
        chk("rst_start", 32'(uart_start), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_tx_in", 32'(uart_tx_in), 32'h00);
        rst = 1'b0;

        // Single byte: visible two edges after the push, gap then idle
        push_byte(8'hA5);
        chk("sb_empty_after_push", 32'(empty), 32'd0);
        chk("sb_start_not_yet", 32'(uart_start), 32'd0);
        tick();
        chk("sb_start", 32'(uart_start), 32'd1);
        chk("sb_data", 32'(uart_tx_in), 32'hA5);
        tick();
        tick();
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        chk("sb_start_drop", 32'(uart_start), 32'd0);
        chk("sb_busy_in_gap", 32'(busy), 32'd1);
        repeat (IDLE_GAP - 1) tick();
        chk("sb_idle", 32'(busy), 32'd0);
        check_delivery("single");

        // Asynchronous reset in the middle of a byte
        push_byte(8'h3C);
        push_byte(8'h5A);
        tick();
        tick();
        chk("mr_in_send", 32'(uart_start), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_start", 32'(uart_start), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_overflow", 32'(overflow), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        got_q.delete();
        acc_log.delete();

        // Burst 0x0A..0x13 with the uart stalled, then released
        peak = 0;
        for (int i = 0; i < 10; i++) push_byte(8'(8'h0A + i));
        tick();
        chk("burst_peak", 32'(peak), 32'd9);
        resp_pct = 40;
        drain();
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            chk("burst_value", 32'(got_q[i]), 32'(8'h0A + i));
        end
        check_delivery("burst");

        // Push and pop on the same edge at count 3
        for (int i = 0; i < 4; i++) push_byte(8'(8'h60 + i));
        chk("pp_count_pre", 32'(count), 32'd3);
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        repeat (IDLE_GAP - 1) tick();
        push_byte(8'h6F);
        chk("pp_count", 32'(count), 32'd3);
        chk("pp_start", 32'(uart_start), 32'd1);
        chk("pp_data", 32'(uart_tx_in), 32'h61);
        drain();
        check_delivery("pushpop");

        // Overflow: 18 pushes with the uart stalled; one byte is already in
        // flight, so 17 are accepted and the 18th is dropped
        for (int i = 0; i < 18; i++) push_byte(8'(8'h40 + i));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_accepted", 32'(acc_log.size()), 32'd17);
        drain();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        check_delivery("overflow");

        // tx_done stuck high across IDLE never completes the next byte
        uart_tx_done = 1'b1;
        tick();
        tick();
        push_byte(8'h77);
        tick();
        repeat (5) tick();
        chk("stuck_hold", 32'(uart_start), 32'd1);
        uart_tx_done = 1'b0;
        tick();
        chk("stuck_still", 32'(uart_start), 32'd1);
        uart_tx_done = 1'b1;
        tick();
        uart_tx_done = 1'b0;
        chk("stuck_done", 32'(uart_start), 32'd0);
        drain();
        check_delivery("stuck");

        // Random traffic against the model
        resp_en  = 1'b1;
        resp_pct = 30;
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 99) < 40);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        drain();
        check_delivery("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
